// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_tx_fifo                                                        |
// | Brief  : UART transmitter with internal baud divider and TX FIFO.            |
// |          Configurable data width, parity (none/odd/even) and stop bits.      |
// | Rev    : 1.0  initial release                                                |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 push, pop, baud_end;
  logic [DATA_BITS-1:0] head;

  assign head       = mem_q[rd_ptr_q];
  assign data_ready = (count_q != FULL);
  assign push       = data_valid && data_ready;
  assign baud_end   = (baud_q == BAUD_LAST);
  assign txd        = txd_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  // FIFO storage: payload only, validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  // FIFO occupancy: a simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
  end

  // FIFO pointers and occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Frame sequencer: next state, baud/bit counters and next txd level
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) baud_d = baud_end ? '0 : baud_q + BW'(1);
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            txd_d   = shift_q[1];
          end
        end
      end
      S_PAR: begin
        if (baud_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (bit_q == STOP_LAST) begin
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
    // Loading a word always starts a fresh frame with a zeroed baud counter,
    // so back-to-back frames carry no idle gap and no timing drift.
    if (pop) begin
      state_d = S_START;
      baud_d  = '0;
      shift_d = head;
      par_d   = (PARITY == 1) ? ~(^head) : (^head);
      txd_d   = 1'b0;
    end
  end

  // Sequencer registers; txd is registered so the pin never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_tx_fifo                                                     |
// | Brief  : Directed self-checking bench for uart_tx_fifo, four parameter sets. |
// | Rev    : 1.0  initial release                                                |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int CD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 8N1, depth 4
  logic [7:0] a_din = '0;
  logic       a_v   = 1'b0;
  logic       a_rdy, a_txd, a_busy;
  logic [2:0] a_cnt;
  // Instance B: 8E1
  logic [7:0] b_din = '0;
  logic       b_v   = 1'b0;
  logic       b_rdy, b_txd, b_busy;
  logic [2:0] b_cnt;
  // Instance C: 8O1
  logic [7:0] c_din = '0;
  logic       c_v   = 1'b0;
  logic       c_rdy, c_txd, c_busy;
  logic [2:0] c_cnt;
  // Instance D: 7N2
  logic [6:0] d_din = '0;
  logic       d_v   = 1'b0;
  logic       d_rdy, d_txd, d_busy;
  logic [2:0] d_cnt;

  uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_din), .data_valid(a_v), .data_ready(a_rdy),
    .txd(a_txd), .busy(a_busy), .fifo_count(a_cnt));
  uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_din), .data_valid(b_v), .data_ready(b_rdy),
    .txd(b_txd), .busy(b_busy), .fifo_count(b_cnt));
  uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .data_in(c_din), .data_valid(c_v), .data_ready(c_rdy),
    .txd(c_txd), .busy(c_busy), .fifo_count(c_cnt));
  uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .rst_n(rst_n), .data_in(d_din), .data_valid(d_v), .data_ready(d_rdy),
    .txd(d_txd), .busy(d_busy), .fifo_count(d_cnt));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic txd_of(input int s);
    case (s)
      0:       return a_txd;
      1:       return b_txd;
      2:       return c_txd;
      default: return d_txd;
    endcase
  endfunction

  // lv holds the hand-computed bit levels of one frame, index 0 = start bit
  task automatic expect_frame(input int s, input logic [15:0] lv, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < CD; k++) begin
        @(negedge clk);
        chk($sformatf("%s_lvl%0d_clk%0d", tag, i, k), {31'd0, txd_of(s)}, {31'd0, lv[i]});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_txd", a_txd, 1);
    chk("rst_rdy", a_rdy, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_cnt", a_cnt, 0);
    rst_n = 1'b1;

    // 1: asynchronous reset mid-frame
    @(negedge clk); a_din = 8'h3C; a_v = 1'b1;
    @(negedge clk); a_v = 1'b0;
    repeat (8) @(negedge clk);
    chk("s1_bit0_low", a_txd, 0);
    chk("s1_busy", a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s1_async_txd", a_txd, 1);
    chk("s1_async_rdy", a_rdy, 1);
    chk("s1_async_busy", a_busy, 0);
    chk("s1_async_cnt", a_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("s1_after_txd", a_txd, 1);
    chk("s1_after_busy", a_busy, 0);

    // 2: 8N1 0x55
    @(negedge clk); a_din = 8'h55; a_v = 1'b1;
    @(negedge clk); a_v = 1'b0;
    chk("s2_cnt_after_push", a_cnt, 1);
    chk("s2_latency_high", a_txd, 1);
    expect_frame(0, 16'h02AA, 10, "s2");
    @(negedge clk);
    chk("s2_idle_txd", a_txd, 1);
    chk("s2_idle_busy", a_busy, 0);

    // 3: parity
    @(negedge clk); b_din = 8'h07; b_v = 1'b1;
    @(negedge clk); b_v = 1'b0;
    expect_frame(1, 16'h060E, 11, "s3_even07");
    @(negedge clk);
    chk("s3_even07_busy", b_busy, 0);
    @(negedge clk); c_din = 8'h07; c_v = 1'b1;
    @(negedge clk); c_v = 1'b0;
    expect_frame(2, 16'h040E, 11, "s3_odd07");
    @(negedge clk);
    chk("s3_odd07_busy", c_busy, 0);
    @(negedge clk); b_din = 8'h03; b_v = 1'b1;
    @(negedge clk); b_v = 1'b0;
    expect_frame(1, 16'h0406, 11, "s3_even03");
    @(negedge clk);
    chk("s3_even03_busy", b_busy, 0);

    // 4: FIFO fill, full-drop, back-to-back frames
    @(negedge clk); a_din = 8'h11; a_v = 1'b1;
    @(negedge clk);
    chk("s4_cnt1", a_cnt, 1);
    fork
      begin
        a_din = 8'h12;
        @(negedge clk); a_din = 8'h13;
        @(negedge clk); a_din = 8'h14;
        @(negedge clk); a_din = 8'h15;
        @(negedge clk);
        chk("s4_full_cnt", a_cnt, 4);
        chk("s4_full_rdy", a_rdy, 0);
        a_din = 8'h66;
        repeat (3) @(negedge clk);
        chk("s4_full_ignored_cnt", a_cnt, 4);
        a_v = 1'b0;
      end
      begin
        expect_frame(0, 16'h0222, 10, "s4_w11");
        expect_frame(0, 16'h0224, 10, "s4_w12");
        expect_frame(0, 16'h0226, 10, "s4_w13");
        expect_frame(0, 16'h0228, 10, "s4_w14");
        expect_frame(0, 16'h022A, 10, "s4_w15");
      end
    join
    @(negedge clk);
    chk("s4_end_txd", a_txd, 1);
    chk("s4_end_busy", a_busy, 0);
    chk("s4_end_cnt", a_cnt, 0);

    // 5: 7 data bits, 2 stop bits, queued follow-on word
    @(negedge clk); d_din = 7'h7F; d_v = 1'b1;
    @(negedge clk); d_din = 7'h00;
    fork
      begin
        @(negedge clk); d_v = 1'b0;
      end
      begin
        expect_frame(3, 16'h03FE, 10, "s5_w7f");
        expect_frame(3, 16'h0300, 10, "s5_w00");
      end
    join
    @(negedge clk);
    chk("s5_end_txd", d_txd, 1);
    chk("s5_end_busy", d_busy, 0);

    // 6: reset during data bit 3 of 0xA5 with two words queued
    @(negedge clk); a_din = 8'hA5; a_v = 1'b1;
    @(negedge clk); a_din = 8'h01;
    @(negedge clk); a_din = 8'h02;
    @(negedge clk); a_v = 1'b0;
    chk("s6_queued", a_cnt, 2);
    repeat (16) @(negedge clk);
    chk("s6_bit3_low", a_txd, 0);
    chk("s6_busy", a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_async_txd", a_txd, 1);
    chk("s6_async_cnt", a_cnt, 0);
    chk("s6_async_rdy", a_rdy, 1);
    chk("s6_async_busy", a_busy, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk($sformatf("s6_quiet_%0d", i), a_txd, 1);
    end
    chk("s6_final_busy", a_busy, 0);
    chk("s6_final_cnt", a_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
